// File: rtl/bullet_pool.sv
// Pool of up to NUM_SLOTS player bullets. On each frame step every active slot is
// erased, moved up, collision-checked against the enemy grid and redrawn as a pixel stream.
module bullet_pool #(
    parameter int          NUM_SLOTS = 4,
    parameter int          X_W       = 9,
    parameter int          Y_W       = 8,
    parameter int          BULLET_W  = 1,
    parameter int          BULLET_H  = 4,
    parameter int          SPEED     = 2,
    parameter int          E_COLS    = 9,
    parameter int          E_ROWS    = 2,
    parameter int          E_PITCH_X = 28,
    parameter int          E_PITCH_Y = 25,
    parameter int          E_W       = 20,
    parameter int          E_H       = 16,
    parameter logic [2:0]  B_COLOUR  = 3'b101,
    localparam int         KI_W      = (E_ROWS * E_COLS > 1) ? $clog2(E_ROWS * E_COLS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fire,
    input  logic [X_W-1:0]             fire_x,
    input  logic [Y_W-1:0]             fire_y,
    output logic                       fire_accepted,
    input  logic                       step,
    output logic                       busy,
    output logic                       done,
    input  logic [X_W-1:0]             anchor_x,
    input  logic [Y_W-1:0]             anchor_y,
    input  logic [E_ROWS*E_COLS-1:0]   alive_in,
    output logic                       kill_valid,
    output logic [KI_W-1:0]            kill_index,
    output logic                       pix_valid,
    output logic [X_W-1:0]             pix_x,
    output logic [Y_W-1:0]             pix_y,
    output logic [2:0]                 pix_colour,
    output logic [NUM_SLOTS-1:0]       active_mask
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = (BULLET_W > 1) ? $clog2(BULLET_W) : 1;
    localparam int RW = (BULLET_H > 1) ? $clog2(BULLET_H) : 1;
    localparam int XE = X_W + 2;
    localparam int YE = Y_W + 2;

    typedef enum logic [2:0] {IDLE, SEL, ERASE, MOVE, CHECK, DRAW, DONE} state_t;

    state_t               state;
    logic [SW-1:0]        s;
    logic [X_W-1:0]       x_r [NUM_SLOTS];
    logic [Y_W-1:0]       y_r [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] active;
    logic [CW-1:0]        pc;
    logic [RW-1:0]        pr;

    logic                 free_found;
    logic [SW-1:0]        free_idx;
    logic [SW-1:0]        slot_cand;
    logic                 last_slot;
    logic                 raster_last;
    logic [CW-1:0]        nxt_pc;
    logic [RW-1:0]        nxt_pr;
    logic                 hit;
    logic [KI_W-1:0]      hit_idx;
    logic [KI_W-1:0]      cand;
    logic [XE-1:0]        bx;
    logic [YE-1:0]        by;

    assign busy        = (state != IDLE);
    assign active_mask = active;
    assign last_slot   = (s == SW'(NUM_SLOTS - 1));
    assign bx          = XE'(x_r[s]);
    assign by          = YE'(y_r[s]);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        slot_cand  = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slot_cand = SW'(i);
            if (!free_found && !active[slot_cand]) begin
                free_found = 1'b1;
                free_idx   = slot_cand;
            end
        end
    end

    // Row-major raster walk: column counter wraps into the row counter.
    always_comb begin
        raster_last = (pc == CW'(BULLET_W - 1)) && (pr == RW'(BULLET_H - 1));
        if (pc == CW'(BULLET_W - 1)) begin
            nxt_pc = '0;
            nxt_pr = pr + 1'b1;
        end else begin
            nxt_pc = pc + 1'b1;
            nxt_pr = pr;
        end
    end

    // Bounds widened by two bits so anchor + offset never wraps; first match is lowest index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        cand    = '0;
        for (int unsigned r = 0; r < E_ROWS; r++) begin
            for (int unsigned c = 0; c < E_COLS; c++) begin
                cand = KI_W'(r * E_COLS + c);
                if (!hit && alive_in[cand]
                    && (bx >= XE'(anchor_x) + XE'(c * E_PITCH_X))
                    && (bx <= XE'(anchor_x) + XE'(c * E_PITCH_X + E_W - 1))
                    && (by >= YE'(anchor_y) + YE'(r * E_PITCH_Y))
                    && (by <= YE'(anchor_y) + YE'(r * E_PITCH_Y + E_H - 1))) begin
                    hit     = 1'b1;
                    hit_idx = cand;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            s             <= '0;
            x_r           <= '{default: '0};
            y_r           <= '{default: '0};
            active        <= '0;
            pc            <= '0;
            pr            <= '0;
            fire_accepted <= 1'b0;
            done          <= 1'b0;
            kill_valid    <= 1'b0;
            kill_index    <= '0;
            pix_valid     <= 1'b0;
            pix_x         <= '0;
            pix_y         <= '0;
            pix_colour    <= '0;
        end else begin
            fire_accepted <= 1'b0;
            done          <= 1'b0;
            kill_valid    <= 1'b0;
            kill_index    <= '0;
            case (state)
                IDLE: begin
                    if (fire && free_found) begin
                        active[free_idx] <= 1'b1;
                        x_r[free_idx]    <= fire_x;
                        y_r[free_idx]    <= fire_y;
                        fire_accepted    <= 1'b1;
                    end
                    if (step) begin
                        state <= SEL;
                        s     <= '0;
                    end
                end
                SEL: begin
                    if (active[s]) begin
                        state      <= ERASE;
                        pc         <= '0;
                        pr         <= '0;
                        pix_valid  <= 1'b1;
                        pix_x      <= x_r[s];
                        pix_y      <= y_r[s];
                        pix_colour <= '0;
                    end else if (last_slot) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        s <= s + 1'b1;
                    end
                end
                ERASE, DRAW: begin
                    if (!raster_last) begin
                        pc    <= nxt_pc;
                        pr    <= nxt_pr;
                        pix_x <= x_r[s] + X_W'(nxt_pc);
                        pix_y <= y_r[s] + Y_W'(nxt_pr);
                    end else begin
                        pix_valid  <= 1'b0;
                        pix_x      <= '0;
                        pix_y      <= '0;
                        pix_colour <= '0;
                        if (state == ERASE) begin
                            state <= MOVE;
                        end else if (last_slot) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SEL;
                            s     <= s + 1'b1;
                        end
                    end
                end
                MOVE: begin
                    if (y_r[s] < Y_W'(SPEED)) begin
                        active[s] <= 1'b0;
                        if (last_slot) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SEL;
                            s     <= s + 1'b1;
                        end
                    end else begin
                        y_r[s] <= y_r[s] - Y_W'(SPEED);
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        kill_valid <= 1'b1;
                        kill_index <= hit_idx;
                        active[s]  <= 1'b0;
                        if (last_slot) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SEL;
                            s     <= s + 1'b1;
                        end
                    end else begin
                        state      <= DRAW;
                        pc         <= '0;
                        pr         <= '0;
                        pix_valid  <= 1'b1;
                        pix_x      <= x_r[s];
                        pix_y      <= y_r[s];
                        pix_colour <= B_COLOUR;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: fire/step sequences with hand-computed pixel, kill,
// mask and frame-latency expectations.
module tb_bullet_pool;

    logic        clk = 1'b0;
    logic        reset;
    logic        fire;
    logic [8:0]  fire_x;
    logic [7:0]  fire_y;
    logic        fire_accepted;
    logic        step;
    logic        busy;
    logic        done;
    logic [8:0]  anchor_x;
    logic [7:0]  anchor_y;
    logic [17:0] alive_in;
    logic        kill_valid;
    logic [4:0]  kill_index;
    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [2:0]  pix_colour;
    logic [3:0]  active_mask;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int pb, kb, db;
    logic [19:0] pix_q[$];
    int          kill_q[$];

    always #5 clk = ~clk;

    bullet_pool #(.NUM_SLOTS(4), .X_W(9), .Y_W(8)) dut (
        .clk(clk), .reset(reset), .fire(fire), .fire_x(fire_x), .fire_y(fire_y),
        .fire_accepted(fire_accepted), .step(step), .busy(busy), .done(done),
        .anchor_x(anchor_x), .anchor_y(anchor_y), .alive_in(alive_in),
        .kill_valid(kill_valid), .kill_index(kill_index), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .active_mask(active_mask)
    );

    always @(negedge clk) begin
        if (pix_valid) pix_q.push_back({pix_x, pix_y, pix_colour});
        if (kill_valid) kill_q.push_back(int'(kill_index));
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick;
        reset = 1'b0;
    endtask

    task automatic do_fire(input logic [8:0] fx, input logic [7:0] fy,
                           input logic ea, input logic [3:0] em, input string tag);
        fire = 1'b1; fire_x = fx; fire_y = fy;
        tick;
        fire = 1'b0;
        chk({tag, "_acc"}, 32'(fire_accepted), 32'(ea));
        chk({tag, "_mask"}, 32'(active_mask), 32'(em));
    endtask

    task automatic start_step;
        pb = pix_q.size(); kb = kill_q.size(); db = done_cnt;
        step = 1'b1;
        tick;
        step = 1'b0;
        cyc = 1;
    endtask

    task automatic finish_frame(input int exp_cyc, input string tag);
        while (done !== 1'b1 && cyc < 300) tick;
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        tick;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_done_once"}, 32'(done_cnt - db), 32'd1);
    endtask

    task automatic chk_pix(input int k, input logic [8:0] ex, input logic [7:0] ey,
                           input logic [2:0] ec, input string tag);
        logic [19:0] got;
        got = (pb + k < pix_q.size()) ? pix_q[pb + k] : 'x;
        chk(tag, 32'(got), 32'({ex, ey, ec}));
    endtask

    task automatic hit_frame(input logic [8:0] fx, input logic [7:0] fy,
                             input int exp_kill, input string tag);
        do_reset(1);
        do_fire(fx, fy, 1'b1, 4'b0001, tag);
        start_step;
        finish_frame((exp_kill >= 0) ? 11 : 15, tag);
        chk({tag, "_nkill"}, 32'(kill_q.size() - kb), (exp_kill >= 0) ? 32'd1 : 32'd0);
        if (exp_kill >= 0) chk({tag, "_kidx"}, 32'(kill_q[kb]), 32'(exp_kill));
        chk({tag, "_mask_after"}, 32'(active_mask), (exp_kill >= 0) ? 32'd0 : 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fire = 1'b0; step = 1'b0; fire_x = '0; fire_y = '0;
        anchor_x = 9'd8; anchor_y = 8'd10; alive_in = '0;
        tick; tick;
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mask", 32'(active_mask), 32'd0);
        chk("rst_pix", 32'(pix_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_kill", 32'(kill_valid), 32'd0);

        // Reset arriving mid-frame
        do_fire(9'd50, 8'd100, 1'b1, 4'b0001, "mid_fire");
        start_step;
        repeat (3) tick;
        chk("mid_pixvalid", 32'(pix_valid), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        db = done_cnt;
        do_reset(3);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_mask", 32'(active_mask), 32'd0);
        chk("mid_rst_pix", 32'(pix_valid), 32'd0);
        repeat (10) tick;
        chk("mid_rst_nodone", 32'(done_cnt - db), 32'd0);
        start_step;
        finish_frame(5, "empty");
        chk("empty_npix", 32'(pix_q.size() - pb), 32'd0);

        // Single bullet
        do_fire(9'd100, 8'd200, 1'b1, 4'b0001, "single");
        start_step;
        finish_frame(15, "single");
        for (int i = 0; i < 4; i++) chk_pix(i, 9'd100, 8'(200 + i), 3'b000, "single_erase");
        for (int i = 0; i < 4; i++) chk_pix(4 + i, 9'd100, 8'(198 + i), 3'b101, "single_draw");
        chk("single_npix", 32'(pix_q.size() - pb), 32'd8);
        chk("single_nkill", 32'(kill_q.size() - kb), 32'd0);
        chk("single_mask", 32'(active_mask), 32'd1);

        // Top exit
        do_reset(1);
        do_fire(9'd60, 8'd1, 1'b1, 4'b0001, "top");
        start_step;
        finish_frame(10, "top");
        for (int i = 0; i < 4; i++) chk_pix(i, 9'd60, 8'(1 + i), 3'b000, "top_erase");
        chk("top_npix", 32'(pix_q.size() - pb), 32'd4);
        chk("top_mask", 32'(active_mask), 32'd0);
        chk("top_nkill", 32'(kill_q.size() - kb), 32'd0);

        // Collisions, anchor (8,10)
        alive_in = '1;
        hit_frame(9'd41, 8'd27, 1, "hit_r0c1");
        chk("hit_npix", 32'(pix_q.size() - pb), 32'd4);
        hit_frame(9'd41, 8'd42, 10, "hit_r1c1");
        hit_frame(9'd55, 8'd27, 1, "hit_xedge");
        hit_frame(9'd56, 8'd27, -1, "miss_xedge");
        hit_frame(9'd41, 8'd28, -1, "miss_yedge");
        hit_frame(9'd8, 8'd12, 0, "hit_r0c0");
        alive_in = 18'h3FFFD;
        hit_frame(9'd41, 8'd27, -1, "dead1");
        for (int i = 0; i < 4; i++) chk_pix(4 + i, 9'd41, 8'(25 + i), 3'b101, "dead1_draw");

        // Pool full and fire while busy
        alive_in = '0;
        do_reset(1);
        do_fire(9'd10, 8'd100, 1'b1, 4'b0001, "pool0");
        do_fire(9'd20, 8'd1,   1'b1, 4'b0011, "pool1");
        do_fire(9'd30, 8'd100, 1'b1, 4'b0111, "pool2");
        do_fire(9'd40, 8'd100, 1'b1, 4'b1111, "pool3");
        do_fire(9'd80, 8'd80,  1'b0, 4'b1111, "pool_full");
        start_step;
        repeat (19) tick;
        fire = 1'b1; fire_x = 9'd90; fire_y = 8'd90;
        tick;
        fire = 1'b0;
        chk("busy_fire_acc", 32'(fire_accepted), 32'd0);
        chk("busy_fire_mask", 32'(active_mask), 32'd13);
        chk("busy_fire_busy", 32'(busy), 32'd1);
        finish_frame(40, "pool_frame");
        chk("pool_npix", 32'(pix_q.size() - pb), 32'd28);
        chk("pool_mask", 32'(active_mask), 32'd13);
        do_fire(9'd70, 8'd150, 1'b1, 4'b1111, "refill");
        start_step;
        finish_frame(45, "refill");
        chk_pix(8, 9'd70, 8'd150, 3'b000, "refill_slot1");

        // Fire and step in the same cycle
        do_reset(1);
        pb = pix_q.size(); kb = kill_q.size(); db = done_cnt;
        fire = 1'b1; fire_x = 9'd120; fire_y = 8'd50; step = 1'b1;
        tick;
        fire = 1'b0; step = 1'b0; cyc = 1;
        chk("simul_acc", 32'(fire_accepted), 32'd1);
        chk("simul_mask", 32'(active_mask), 32'd1);
        chk("simul_busy", 32'(busy), 32'd1);
        finish_frame(15, "simul");
        for (int i = 0; i < 4; i++) chk_pix(i, 9'd120, 8'(50 + i), 3'b000, "simul_erase");
        for (int i = 0; i < 4; i++) chk_pix(4 + i, 9'd120, 8'(48 + i), 3'b101, "simul_draw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
